// File: rtl/parent_pkg.sv
// Shared types and width helpers for the caretaker controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package parent_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COOK      = 3'd1,
        SERVE     = 3'd2,
        WAIT_ACK  = 3'd3,
        REST      = 3'd4,
        GIVE_BOOK = 3'd5,
        STARVE    = 3'd6
    } state_t;

    // One timer serves all three delays, so it is sized for the longest one.
    function automatic int timer_w(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

    // Stock counter must hold 0..pantry inclusive.
    function automatic int stock_w(input int pantry);
        return $clog2(pantry + 1);
    endfunction

endpackage

// File: rtl/parent_timer.sv
// Down-counter shared by cook, ack-timeout and rest delays; flags zero.
// Latency: load takes effect on the next edge; zero is decoded from the register.
// Backpressure: none; counts whenever enabled and holds at zero.
module parent_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         resetb,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load wins over counting; the count parks at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/parent_ctrl.sv
// Caretaker responder: cooks and serves a meal on request, waits for ack, then hands out a book.
// Latency: meal COOK_CYCLES+1 cycles after request is seen in IDLE; book BOOK_DELAY+1 after ack.
// Backpressure: none; a missing ack re-serves up to MAX_RETRY times, then flags a sticky error.
module parent_ctrl
    import parent_pkg::*;
#(
    parameter int COOK_CYCLES = 4,
    parameter int BOOK_DELAY  = 3,
    parameter int ACK_TIMEOUT = 8,
    parameter int MAX_RETRY   = 2,
    parameter int PANTRY      = 15,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic             request,
    input  logic             refill,
    output logic             meal,
    output logic             book,
    output logic             busy,
    output logic             out_of_food,
    output logic             error,
    output logic [CNT_W-1:0] meal_count
);

    localparam int TW = timer_w(COOK_CYCLES, BOOK_DELAY, ACK_TIMEOUT);
    localparam int SW = stock_w(PANTRY);
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [TW-1:0]    COOK_LD    = TW'(COOK_CYCLES - 1);
    localparam logic [TW-1:0]    ACK_LD     = TW'(ACK_TIMEOUT - 1);
    localparam logic [TW-1:0]    BOOK_LD    = TW'(BOOK_DELAY - 1);
    localparam logic [SW-1:0]    STOCK_FULL = SW'(PANTRY);
    localparam logic [RW-1:0]    RETRY_MAX  = RW'(MAX_RETRY);
    localparam logic [CNT_W-1:0] CNT_SAT    = '1;

    state_t           state_q, state_d;
    logic [SW-1:0]    stock_q, stock_d;
    logic [RW-1:0]    retry_q, retry_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             error_q, error_d;
    logic             meal_q, meal_d;
    logic             book_q, book_d;
    logic             busy_q, busy_d;
    logic             oof_q, oof_d;

    logic             tmr_load;
    logic [TW-1:0]    tmr_val;
    logic             tmr_zero;

    parent_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .resetb   (resetb),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (!tmr_load),
        .zero     (tmr_zero)
    );

    // Next-state, bookkeeping and registered-output decode.
    always_comb begin
        state_d  = state_q;
        stock_d  = stock_q;
        retry_d  = retry_q;
        count_d  = count_q;
        error_d  = error_q;
        tmr_load = 1'b0;
        tmr_val  = '0;

        case (state_q)
            IDLE: begin
                if (request) begin
                    if (stock_q != '0) begin
                        state_d  = COOK;
                        tmr_load = 1'b1;
                        tmr_val  = COOK_LD;
                    end else begin
                        state_d = STARVE;
                    end
                end
            end
            COOK: begin
                // Abandoning the cook costs no stock; it is only taken at SERVE.
                if (!request) begin
                    state_d = IDLE;
                end else if (tmr_zero) begin
                    state_d = SERVE;
                end
            end
            SERVE: begin
                if (stock_q != '0) begin
                    stock_d = stock_q - 1'b1;
                end
                tmr_load = 1'b1;
                tmr_val  = ACK_LD;
                state_d  = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (!request) begin
                    state_d  = REST;
                    retry_d  = '0;
                    tmr_load = 1'b1;
                    tmr_val  = BOOK_LD;
                    if (count_q != CNT_SAT) begin
                        count_d = count_q + 1'b1;
                    end
                end else if (tmr_zero) begin
                    if (retry_q < RETRY_MAX) begin
                        if (stock_q != '0) begin
                            retry_d = retry_q + 1'b1;
                            state_d = SERVE;
                        end else begin
                            retry_d = '0;
                            state_d = STARVE;
                        end
                    end else begin
                        error_d = 1'b1;
                        retry_d = '0;
                        state_d = IDLE;
                    end
                end
            end
            REST: begin
                if (tmr_zero) begin
                    state_d = GIVE_BOOK;
                end
            end
            GIVE_BOOK: begin
                state_d = IDLE;
            end
            STARVE: begin
                if (refill) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A reload overrides any decrement in the same cycle.
        if (refill) begin
            stock_d = STOCK_FULL;
        end

        meal_d = (state_d == SERVE);
        book_d = (state_d == GIVE_BOOK);
        busy_d = (state_d != IDLE);
        oof_d  = (state_d == STARVE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q <= IDLE;
            stock_q <= STOCK_FULL;
            retry_q <= '0;
            count_q <= '0;
            error_q <= 1'b0;
            meal_q  <= 1'b0;
            book_q  <= 1'b0;
            busy_q  <= 1'b0;
            oof_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            stock_q <= stock_d;
            retry_q <= retry_d;
            count_q <= count_d;
            error_q <= error_d;
            meal_q  <= meal_d;
            book_q  <= book_d;
            busy_q  <= busy_d;
            oof_q   <= oof_d;
        end
    end

    assign meal        = meal_q;
    assign book        = book_q;
    assign busy        = busy_q;
    assign out_of_food = oof_q;
    assign error       = error_q;
    assign meal_count  = count_q;

endmodule

// File: tb/tb_parent_ctrl.sv
// Directed bench for the caretaker controller with a pulse-timing scoreboard.
// Latency: expected meal/book cycles are queued when stimulus is driven.
// Backpressure: n/a.
module tb_parent_ctrl;

    localparam int COOK = 4;
    localparam int BD   = 3;
    localparam int ACK  = 8;

    logic       clk = 1'b0;
    logic       resetb = 1'b0;
    logic       request = 1'b0, refill = 1'b0;
    logic       meal, book, busy, oof, err;
    logic [7:0] mc;

    logic       request2 = 1'b0, refill2 = 1'b0;
    logic       meal2, book2, busy2, oof2, err2;
    logic [1:0] mc2;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int exp_meal[$], exp_book[$], exp_meal2[$], exp_book2[$];

    parent_ctrl dut (
        .clk(clk), .resetb(resetb), .request(request), .refill(refill),
        .meal(meal), .book(book), .busy(busy), .out_of_food(oof),
        .error(err), .meal_count(mc)
    );

    parent_ctrl #(.PANTRY(2), .CNT_W(2)) dut2 (
        .clk(clk), .resetb(resetb), .request(request2), .refill(refill2),
        .meal(meal2), .book(book2), .busy(busy2), .out_of_food(oof2),
        .error(err2), .meal_count(mc2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Scoreboard: every pulse must match the head of its queue of expected cycles.
    always @(negedge clk) begin : mon
        int e;
        if (resetb) begin
            if (meal) begin
                if (exp_meal.size() != 0) e = exp_meal.pop_front(); else e = -1;
                chk("meal_time", cyc, e);
            end
            if (book) begin
                if (exp_book.size() != 0) e = exp_book.pop_front(); else e = -1;
                chk("book_time", cyc, e);
            end
            if (meal2) begin
                if (exp_meal2.size() != 0) e = exp_meal2.pop_front(); else e = -1;
                chk("meal2_time", cyc, e);
            end
            if (book2) begin
                if (exp_book2.size() != 0) e = exp_book2.pop_front(); else e = -1;
                chk("book2_time", cyc, e);
            end
        end
    end

    // One compliant hungry phase: request, ack one cycle after seeing meal, wait for book.
    task automatic serve_cycle(input bit d2, input bit rf);
        int c, m;
        c = cyc;
        m = c + 1 + COOK;
        if (d2) begin request2 = 1'b1; exp_meal2.push_back(m); end
        else    begin request  = 1'b1; exp_meal.push_back(m);  end
        tick(1);
        chk("busy_cook", d2 ? busy2 : busy, 1);
        tick(m - cyc);
        if (rf) refill = 1'b1;
        tick(1);
        refill = 1'b0;
        if (d2) begin request2 = 1'b0; exp_book2.push_back(m + 2 + BD); end
        else    begin request  = 1'b0; exp_book.push_back(m + 2 + BD);  end
        tick(m + 3 + BD - cyc);
        chk("busy_after_book", d2 ? busy2 : busy, 0);
    endtask

    initial begin
        int c, m, e, r;

        // Reset values
        tick(2);
        chk("rst_meal", meal, 0);
        chk("rst_book", book, 0);
        chk("rst_busy", busy, 0);
        chk("rst_oof", oof, 0);
        chk("rst_err", err, 0);
        chk("rst_count", mc, 0);
        chk("rst_stock", dut.stock_q, 15);
        resetb = 1'b1;
        tick(2);

        // Basic serve with compliant ack
        serve_cycle(0, 0);
        chk("t1_count", mc, 1);
        chk("t1_stock", dut.stock_q, 14);

        // Abort during COOK
        request = 1'b1;
        tick(2);
        request = 1'b0;
        tick(1);
        chk("t2_busy", busy, 0);
        tick(COOK + 3);
        chk("t2_stock", dut.stock_q, 14);
        chk("t2_count", mc, 1);

        // Fresh start, then a child that never acks
        resetb = 1'b0;
        tick(1);
        resetb = 1'b1;
        tick(1);
        c = cyc;
        m = c + 1 + COOK;
        e = m + 3 * (ACK + 1);
        request = 1'b1;
        exp_meal.push_back(m);
        exp_meal.push_back(m + ACK + 1);
        exp_meal.push_back(m + 2 * (ACK + 1));
        tick(e - 1 - cyc);
        chk("t3_err_before", err, 0);
        tick(1);
        chk("t3_err", err, 1);
        chk("t3_busy", busy, 0);
        chk("t3_count", mc, 0);
        chk("t3_stock", dut.stock_q, 12);
        request = 1'b0;
        tick(2);
        chk("t3_idle", busy, 0);
        chk("t3_err_sticky", err, 1);

        // Small pantry: two meals, starve, refill, then count saturation
        serve_cycle(1, 0);
        serve_cycle(1, 0);
        chk("t4_count2", mc2, 2);
        chk("t4_stock0", dut2.stock_q, 0);
        request2 = 1'b1;
        tick(1);
        chk("t4_oof", oof2, 1);
        chk("t4_busy", busy2, 1);
        request2 = 1'b0;
        tick(2);
        chk("t4_oof_hold", oof2, 1);
        request2 = 1'b1;
        refill2 = 1'b1;
        r = cyc;
        tick(1);
        refill2 = 1'b0;
        chk("t4_oof_clear", oof2, 0);
        chk("t4_idle", busy2, 0);
        chk("t4_refilled", dut2.stock_q, 2);
        chk("t4_cyc", cyc, r + 1);
        serve_cycle(1, 0);
        chk("t4_count3", mc2, 3);
        serve_cycle(1, 0);
        chk("t4_count_sat", mc2, 3);
        chk("t4_err2", err2, 0);

        // Reset in the middle of WAIT_ACK
        c = cyc;
        m = c + 1 + COOK;
        request = 1'b1;
        exp_meal.push_back(m);
        tick(m + 2 - cyc);
        chk("t5_busy_wait", busy, 1);
        resetb = 1'b0;
        #1;
        chk("t5_meal", meal, 0);
        chk("t5_book", book, 0);
        chk("t5_busy", busy, 0);
        chk("t5_oof", oof, 0);
        chk("t5_err", err, 0);
        chk("t5_count", mc, 0);
        chk("t5_stock", dut.stock_q, 15);
        request = 1'b0;
        tick(2);
        resetb = 1'b1;
        tick(BD + ACK + 4);
        chk("t5_quiet", busy, 0);

        // Child-like run: two hungry phases with study gaps; refill coincides with first SERVE
        for (int i = 0; i < 2; i++) begin
            serve_cycle(0, (i == 0));
            tick(3);
            chk("t6_count", mc, i + 1);
        end
        chk("t6_stock", dut.stock_q, 14);
        chk("t6_err", err, 0);

        // Every expected pulse must have been seen
        tick(2);
        chk("left_meal", exp_meal.size(), 0);
        chk("left_book", exp_book.size(), 0);
        chk("left_meal2", exp_meal2.size(), 0);
        chk("left_book2", exp_book2.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
